// File: rtl/dsm_sample_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsm_sample_scheduler_if : stereo sample valid/ready stream into the scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
interface dsm_sample_scheduler_if #(
   parameter int MSB = 16
);
   logic [2*MSB-1:0] S_DATA;
   logic             S_VALID;
   logic             S_READY;

   modport master (output S_DATA, output S_VALID, input S_READY);
   modport slave  (input S_DATA, input S_VALID, output S_READY);
endinterface
`default_nettype wire

// File: rtl/dsm_sample_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsm_sample_scheduler : FIFO-buffered, divider-paced stereo feed for DSM DACs.
// Optional soft mute ramp: define DSM_SCHED_SOFT_MUTE_EN.   Revision: 1.0
// ---------------------------------------------------------------------------
module dsm_sample_scheduler #(
   parameter int MSB        = 16,
   parameter int OSR_DIV    = 256,
   parameter int FIFO_DEPTH = 4,
   parameter int RAMP_SHIFT = 8
) (
   input  wire logic                          CLK,
   input  wire logic                          RESET,
   input  wire logic                          ENABLE,
   dsm_sample_scheduler_if.slave              s_bus,
   output logic [MSB-1:0]                     DAC_L,
   output logic [MSB-1:0]                     DAC_R,
   output logic                               SAMPLE_TICK,
   output logic                               UNDERRUN,
   output logic [1:0]                         STATE,
   output logic [$clog2(FIFO_DEPTH):0]        FIFO_LEVEL
);
   localparam int c_PW = $clog2(FIFO_DEPTH);
   localparam int c_LW = c_PW + 1;
   localparam int c_DW = $clog2(OSR_DIV);

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_PRIME  = 2'd1;
   localparam logic [1:0] c_ST_RUN    = 2'd2;
   localparam logic [1:0] c_ST_STARVE = 2'd3;

   localparam logic [MSB-1:0]  c_MID      = {1'b1, {(MSB-1){1'b0}}};
   localparam logic [MSB-1:0]  c_STEP     = MSB'(1) << RAMP_SHIFT;
   localparam logic [c_LW-1:0] c_DEPTH    = c_LW'(FIFO_DEPTH);
   localparam logic [c_LW-1:0] c_HALF     = c_LW'(FIFO_DEPTH / 2);
   localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(OSR_DIV - 1);

   logic [1:0]       r_state, w_state_nxt;
   logic [c_LW-1:0]  r_level;
   logic [c_PW-1:0]  r_wr_ptr, r_rd_ptr;
   logic [2*MSB-1:0] r_mem [FIFO_DEPTH];
   logic [c_DW-1:0]  r_div;
   logic             r_underrun;
   logic             w_ready, w_push, w_pop, w_tick, w_underrun, w_div_run;

   // One step of the mute ramp toward mid-scale, landing exactly on it.
   function automatic logic [MSB-1:0] f_ramp(input logic [MSB-1:0] x);
      logic [MSB-1:0] d;
      if (x > c_MID) begin
         d      = x - c_MID;
         f_ramp = (d <= c_STEP) ? c_MID : x - c_STEP;
      end else begin
         d      = c_MID - x;
         f_ramp = (d <= c_STEP) ? c_MID : x + c_STEP;
      end
   endfunction

   assign w_ready    = (r_state != c_ST_IDLE) && (r_level < c_DEPTH);
   assign w_push     = s_bus.S_VALID && w_ready && ENABLE;
   assign w_tick     = (r_div == c_DIV_LAST);
   assign w_pop      = ENABLE && (r_state == c_ST_RUN) && w_tick && (r_level != '0);
   assign w_underrun = ENABLE && (r_state == c_ST_RUN) && w_tick && (r_level == '0);

`ifdef DSM_SCHED_SOFT_MUTE_EN
   logic w_at_mid, w_ramp;
   assign w_at_mid  = (DAC_L == c_MID) && (DAC_R == c_MID);
   // The divider keeps pacing the ramp after ENABLE falls until both channels settle.
   assign w_div_run = (r_state == c_ST_RUN) || (r_state == c_ST_STARVE) ||
                      ((r_state == c_ST_IDLE) && !w_at_mid);
   assign w_ramp    = w_tick && ((r_state == c_ST_IDLE) || (r_state == c_ST_STARVE) ||
                                 w_underrun || !ENABLE);
`else
   assign w_div_run = ENABLE && ((r_state == c_ST_RUN) || (r_state == c_ST_STARVE));
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
`ifdef DSM_SCHED_SOFT_MUTE_EN
         c_ST_IDLE:   if (ENABLE && w_at_mid) w_state_nxt = c_ST_PRIME;
`else
         c_ST_IDLE:   if (ENABLE) w_state_nxt = c_ST_PRIME;
`endif
         c_ST_PRIME:  if (r_level >= c_HALF) w_state_nxt = c_ST_RUN;
         c_ST_RUN:    if (w_tick && (r_level == '0)) w_state_nxt = c_ST_STARVE;
         c_ST_STARVE: if (w_tick && (r_level >= c_HALF)) w_state_nxt = c_ST_RUN;
         default:     w_state_nxt = c_ST_IDLE;
      endcase
      if (!ENABLE) w_state_nxt = c_ST_IDLE;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= c_ST_IDLE;
         r_underrun <= 1'b0;
         r_div      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_underrun <= w_underrun;
         if (w_div_run) r_div <= w_tick ? '0 : r_div + c_DW'(1);
         else           r_div <= '0;
      end
   end

   // Dropping ENABLE flushes the queue, discarding any handshake in that cycle.
   always_ff @(posedge CLK) begin
      if (RESET || !ENABLE) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + c_LW'(1);
            2'b01:   r_level <= r_level - c_LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wr_ptr] <= s_bus.S_DATA;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         DAC_L <= c_MID;
         DAC_R <= c_MID;
      end else if (w_pop) begin
         DAC_L <= r_mem[r_rd_ptr][2*MSB-1:MSB];
         DAC_R <= r_mem[r_rd_ptr][MSB-1:0];
`ifdef DSM_SCHED_SOFT_MUTE_EN
      end else if (w_ramp) begin
         DAC_L <= f_ramp(DAC_L);
         DAC_R <= f_ramp(DAC_R);
`else
      end else if (!ENABLE || (r_state == c_ST_IDLE) || (r_state == c_ST_STARVE) || w_underrun) begin
         DAC_L <= c_MID;
         DAC_R <= c_MID;
`endif
      end
   end

   assign s_bus.S_READY = w_ready;
   assign SAMPLE_TICK   = w_tick;
   assign UNDERRUN      = r_underrun;
   assign STATE         = r_state;
   assign FIFO_LEVEL    = r_level;
endmodule
`default_nettype wire

// File: doc/dsm_sample_scheduler.md
# dsm_sample_scheduler

Sample-rate scheduler that feeds a stereo pair of delta-sigma DAC modulators from the USB audio stream. It accepts packed stereo samples from the USB side through a valid/ready handshake and buffers them in a small FIFO. It releases one sample pair per output-sample period, using a clock divider, onto the offset-binary modulator inputs. It primes the FIFO before playback, detects underrun, and drives mid-scale (silence) when idle or starved.

## Interface
- MSB, 16, sample width; modulator inputs are offset-binary, mid-scale = 1<<(MSB-1)
- OSR_DIV, 256, CLK cycles per output sample period (≥4)
- FIFO_DEPTH, 4, FIFO entries; power of two, ≥2
- RAMP_SHIFT, 8, soft-mute step = 1<<RAMP_SHIFT (used only with DSM_SCHED_SOFT_MUTE_EN)

Ports:
- CLK  in  1  single clock for the whole block
- RESET  in  1  synchronous, active-high reset
- ENABLE  in  1  playback enable
- S_DATA  in  2*MSB  {left[2*MSB-1:MSB], right[MSB-1:0]}, offset-binary
- S_VALID  in  1  S_DATA valid
- S_READY  out  1  block can accept S_DATA
- DAC_L  out  MSB  left modulator input (registered)
- DAC_R  out  MSB  right modulator input (registered)
- SAMPLE_TICK  out  1  one-cycle pulse at each sample period boundary
- UNDERRUN  out  1  one-cycle pulse on a RUN→STARVE transition
- STATE  out  2  IDLE=0, PRIME=1, RUN=2, STARVE=3
- FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- Push occurs when S_VALID && S_READY. S_READY = (state≠IDLE) && (level<FIFO_DEPTH).
- Divider counts 0..OSR_DIV-1 and wraps. SAMPLE_TICK is high while count==OSR_DIV-1. Divider is held at 0 in IDLE and PRIME and starts from 0 on PRIME→RUN.
- IDLE: FIFO flushed, level 0, DAC_L/DAC_R = mid-scale. ENABLE=1 → PRIME.
- PRIME: level ≥ FIFO_DEPTH/2 → RUN.
- RUN: on tick with level>0, pop head into DAC_L/DAC_R. On tick with level==0, go to STARVE, pulse UNDERRUN, and set outputs to mute.
- STARVE: outputs mute. On tick with level ≥ FIFO_DEPTH/2 → RUN; no pop on that tick, the first pop is at the next tick. On tick with lower level, stay in STARVE.
- ENABLE=0 in any state → IDLE the next cycle. This flushes the FIFO and discards a push in that same cycle.
- Simultaneous push and pop: both take effect and level is unchanged. Pop and underrun decisions use the registered level, so a push in the tick cycle does not prevent underrun at level 0.
- The FIFO never overflows because S_READY gates pushes. FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: state IDLE, level 0, divider 0, S_READY 0, SAMPLE_TICK 0, UNDERRUN 0, DAC_L = DAC_R = 1<<(MSB-1).
- S_READY rises 1 cycle after ENABLE is sampled high (IDLE→PRIME).
- A pushed word is counted in FIFO_LEVEL the cycle after the handshake.
- PRIME→RUN occurs 1 cycle after the level reaches FIFO_DEPTH/2. The first tick follows OSR_DIV cycles after entering RUN.
- Pop latency: DAC_L/DAC_R update on the cycle after SAMPLE_TICK. UNDERRUN is coincident with that update.
- RESET asserted mid-operation returns everything to reset values the next cycle, regardless of ENABLE or the handshake.

## Configuration
- DSM_SCHED_SOFT_MUTE_EN defined:
  - Mute in STARVE and on entry to IDLE is a ramp. Each tick moves each channel toward mid-scale by 1<<RAMP_SHIFT, clamped exactly at mid-scale.
  - In IDLE the divider keeps running until both channels reach mid-scale, then stops at 0.
  - STATE reads IDLE throughout the ramp.
- Undefined: mute is an immediate jump to mid-scale on the cycle after the triggering tick or ENABLE fall.

## Test plan
- Reset with all inputs 0 → DAC_L = DAC_R = 0x8000, STATE 0, S_READY 0, FIFO_LEVEL 0.
- OSR_DIV=4, DEPTH=4, ENABLE=1, push {0x1234,0xABCD} then {0x0001,0xFFFF} → PRIME→RUN. First tick 4 cycles later; outputs 0x1234/0xABCD the cycle after; the next pair appears 4 cycles later.
- Hold S_VALID=1 continuously → FIFO_LEVEL saturates at 4, S_READY 0, no word lost; output sequence matches input order exactly.
- Stop pushing in RUN → at the first tick with level 0, UNDERRUN pulses once, STATE=3, outputs 0x8000. Push 2 words → RUN at the next tick, with the first pop at the following tick.
- ENABLE dropped with 3 words queued, push in the same cycle → next cycle STATE 0, FIFO_LEVEL 0, outputs 0x8000, S_READY 0.
- With DSM_SCHED_SOFT_MUTE_EN, RAMP_SHIFT=12, output 0xC000, then underrun → outputs step 0xB000, 0xA000, 0x9000, 0x8000 on successive ticks, then hold.
